// File: rtl/clk_div_ctrl.sv
// Run-time controller for the toggle clock divider: round-robin divisor updates applied on falling toggles.
// Optional DIVCTL_CHG_CNT_EN adds a saturating 16-bit count of div_act changes (chg_cnt).
module clk_div_ctrl #(
  parameter int          W           = 8,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   req_valid,
  input  logic [W-1:0] req_div0,
  input  logic [W-1:0] req_div1,
  output logic [1:0]   req_ready,
  output logic         clk_out,
  output logic         tick,
  output logic [W-1:0] div_act,
  output logic         busy,
  output logic         err
`ifdef DIVCTL_CHG_CNT_EN
  ,
  output logic [15:0]  chg_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t       state;
  logic [W-1:0] count, div_pend, div_nxt, hs_div;
  logic         ptr, gidx, hs, wrap;

  // Grant: single valid requester, or the pointer's pick when both are valid.
  always_comb begin
    req_ready = 2'b00;
    gidx      = 1'b0;
    if (!busy) begin
      gidx = (req_valid == 2'b11) ? ptr : req_valid[1];
      if (|req_valid) req_ready = gidx ? 2'b10 : 2'b01;
    end
    hs     = |(req_valid & req_ready);
    hs_div = gidx ? req_div1 : req_div0;
    wrap   = (count == div_act - W'(1));
  end

  // Next divisor: immediate in IDLE or on disable, otherwise only at a falling toggle.
  always_comb begin
    div_nxt = div_act;
    if (state == IDLE || !en) begin
      if (state == PEND)               div_nxt = div_pend;
      else if (hs && hs_div != '0)     div_nxt = hs_div;
    end else if (state == PEND && wrap && clk_out) begin
      div_nxt = div_pend;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      div_act  <= W'(DEFAULT_DIV);
      div_pend <= W'(DEFAULT_DIV);
      ptr      <= 1'b0;
    end else begin
      div_act <= div_nxt;
      tick    <= 1'b0;
      err     <= hs && (hs_div == '0);
      if (hs) ptr <= ~gidx;
      case (state)
        IDLE: begin
          count   <= '0;
          clk_out <= 1'b0;
          if (en) state <= RUN;
        end
        default: begin
          if (!en) begin
            state   <= IDLE;
            count   <= '0;
            clk_out <= 1'b0;
            busy    <= 1'b0;
          end else if (wrap) begin
            count   <= '0;
            clk_out <= ~clk_out;
            tick    <= 1'b1;
            if (state == PEND && clk_out) begin
              state <= RUN;
              busy  <= 1'b0;
            end
          end else begin
            count <= count + W'(1);
          end
        end
      endcase
      // A request accepted while running waits for a falling toggle, never the current one.
      if (state == RUN && en && hs && hs_div != '0) begin
        div_pend <= hs_div;
        state    <= PEND;
        busy     <= 1'b1;
      end
    end
  end

`ifdef DIVCTL_CHG_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                          chg_cnt <= '0;
    else if (div_nxt != div_act && chg_cnt != 16'hFFFF) chg_cnt <= chg_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: vector table for start-up/arbitration, hand sequences for apply/reset/D=1.
module tb_clk_div_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, en;
  logic [1:0]   req_valid;
  logic [W-1:0] req_div0, req_div1;
  logic [1:0]   req_ready;
  logic         clk_out, tick, busy, err;
  logic [W-1:0] div_act;
`ifdef DIVCTL_CHG_CNT_EN
  logic [15:0]  chg_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clk_div_ctrl #(.W(W), .DEFAULT_DIV(3)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid),
    .req_div0(req_div0), .req_div1(req_div1), .req_ready(req_ready),
    .clk_out(clk_out), .tick(tick), .div_act(div_act), .busy(busy), .err(err)
`ifdef DIVCTL_CHG_CNT_EN
    , .chg_cnt(chg_cnt)
`endif
  );

  typedef struct {
    logic         en;
    logic [1:0]   rv;
    logic [W-1:0] d0, d1;
    logic [1:0]   rdy;
    logic         co, tk, bz;
    logic [W-1:0] dv;
    logic         er;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic e, input logic [1:0] rv, input logic [W-1:0] d0, d1,
                              input logic [1:0] rdy, input logic co, tk, bz,
                              input logic [W-1:0] dv, input logic er);
    vec_t v;
    v.en = e; v.rv = rv; v.d0 = d0; v.d1 = d1; v.rdy = rdy;
    v.co = co; v.tk = tk; v.bz = bz; v.dv = dv; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  int k;

  initial begin
    rst = 1'b1; en = 1'b0; req_valid = 2'b00; req_div0 = '0; req_div1 = '0;
    edge1();
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_div_act", div_act, 3);
    rst = 1'b0;

    // IDLE arbitration, start-up cadence at D=3, and a zero-divisor request mid-run
    tbl[0]  = mk(0, 2'b11, 4, 6, 2'b01, 0, 0, 0, 4, 0);
    tbl[1]  = mk(0, 2'b11, 4, 6, 2'b10, 0, 0, 0, 6, 0);
    tbl[2]  = mk(0, 2'b01, 3, 6, 2'b01, 0, 0, 0, 3, 0);
    tbl[3]  = mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 3, 0);
    tbl[4]  = mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 3, 0);
    tbl[5]  = mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 3, 0);
    tbl[6]  = mk(1, 2'b00, 0, 0, 2'b00, 1, 1, 0, 3, 0);
    tbl[7]  = mk(1, 2'b00, 0, 0, 2'b00, 1, 0, 0, 3, 0);
    tbl[8]  = mk(1, 2'b00, 0, 0, 2'b00, 1, 0, 0, 3, 0);
    tbl[9]  = mk(1, 2'b00, 0, 0, 2'b00, 0, 1, 0, 3, 0);
    tbl[10] = mk(1, 2'b10, 0, 0, 2'b10, 0, 0, 0, 3, 1);
    tbl[11] = mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 3, 0);
    tbl[12] = mk(1, 2'b00, 0, 0, 2'b00, 1, 1, 0, 3, 0);
    tbl[13] = mk(1, 2'b00, 0, 0, 2'b00, 1, 0, 0, 3, 0);
    tbl[14] = mk(1, 2'b00, 0, 0, 2'b00, 1, 0, 0, 3, 0);
    tbl[15] = mk(1, 2'b00, 0, 0, 2'b00, 0, 1, 0, 3, 0);

    for (int i = 0; i < 16; i++) begin
      en = tbl[i].en; req_valid = tbl[i].rv; req_div0 = tbl[i].d0; req_div1 = tbl[i].d1;
      #1;
      chk($sformatf("v%0d_req_ready", i), req_ready, tbl[i].rdy);
      edge1();
      chk($sformatf("v%0d_clk_out", i), clk_out, tbl[i].co);
      chk($sformatf("v%0d_tick", i), tick, tbl[i].tk);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].bz);
      chk($sformatf("v%0d_div_act", i), div_act, tbl[i].dv);
      chk($sformatf("v%0d_err", i), err, tbl[i].er);
    end

    // Update 3->5 requested while clk_out low: pending through the rise, applied at the fall
    req_valid = 2'b01; req_div0 = 5;
    #1;
    chk("upd_ready", req_ready, 2'b01);
    edge1();
    chk("upd_busy", busy, 1);
    chk("upd_div_hold", div_act, 3);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("upd_ready_blocked", req_ready, 2'b00);
      edge1();
    end
    req_valid = 2'b00;
    k = 2;
    while (busy && k < 30) begin
      edge1();
      k++;
    end
    chk("apply_latency", k, 5);
    chk("apply_clk_out", clk_out, 0);
    chk("apply_tick", tick, 1);
    chk("apply_div_act", div_act, 5);
    k = 0;
    do begin edge1(); k++; end while (!clk_out && k < 30);
    chk("new_low_phase", k, 5);
    k = 0;
    do begin edge1(); k++; end while (clk_out && k < 30);
    chk("new_high_phase", k, 5);

    // Reset while PEND drops the pending divisor
    req_valid = 2'b10; req_div1 = 7;
    #1;
    chk("pend_ready_r1", req_ready, 2'b10);
    edge1();
    chk("pend_busy", busy, 1);
    req_valid = 2'b00; rst = 1'b1;
    edge1();
    chk("mid_rst_clk_out", clk_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_div_act", div_act, 3);
    rst = 1'b0;
    edge1();
    k = 0;
    do begin edge1(); k++; end while (!clk_out && k < 30);
    chk("post_rst_rise", k, 3);
    chk("post_rst_div_act", div_act, 3);

    // D=1: toggle every cycle
    en = 1'b0;
    edge1();
    chk("dis_clk_out", clk_out, 0);
    req_valid = 2'b01; req_div0 = 1;
    edge1();
    chk("d1_div_act", div_act, 1);
    req_valid = 2'b00; en = 1'b1;
    edge1();
    for (int i = 0; i < 4; i++) begin
      edge1();
      chk($sformatf("d1_clk_out%0d", i), clk_out, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("d1_tick%0d", i), tick, 1);
    end

`ifdef DIVCTL_CHG_CNT_EN
    en = 1'b0; rst = 1'b1;
    edge1();
    chk("cc_rst", chg_cnt, 0);
    rst = 1'b0;
    req_valid = 2'b01; req_div0 = 4; edge1();
    req_div0 = 4; edge1();
    req_div0 = 7; edge1();
    req_div0 = 0; edge1();
    req_valid = 2'b00;
    chk("cc_count", chg_cnt, 2);
    chk("cc_div_act", div_act, 7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
